// File: rtl/side_info_parser.sv
// side_info_parser: captures MP3 Layer III side-info bytes after a header
// and emits frame fields plus per-granule/channel records as strobes.
module side_info_parser #(
  parameter int MONO_BYTES   = 17,
  parameter int STEREO_BYTES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_header,
  input  logic [1:0]  mode,
  input  logic [7:0]  axiid,
  input  logic        side_info_ov,
  output logic [8:0]  main_data_begin,
  output logic [4:0]  private_bits,
  output logic [7:0]  scfsi,
  output logic        hdr_valid,
  output logic        gr,
  output logic        ch,
  output logic [11:0] part2_3_length,
  output logic [8:0]  big_values,
  output logic [7:0]  global_gain,
  output logic [3:0]  scalefac_compress,
  output logic        window_switching,
  output logic [1:0]  block_type,
  output logic        mixed_block,
  output logic [14:0] table_select,
  output logic [8:0]  subblock_gain,
  output logic [3:0]  region0_count,
  output logic [2:0]  region1_count,
  output logic        preselect,
  output logic        scalefac_scale,
  output logic        count1table_select,
  output logic        rec_valid,
  output logic        done,
  output logic        overrun
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, EMIT_HDR, EMIT_REC, DONE
  } state_t;

  state_t       state_q, state_d;
  logic         mono_q, mono_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] cap_q, cap_d;
  logic [1:0]   idx_q, idx_d;

  logic [8:0]  mdb_q, mdb_d;
  logic [4:0]  priv_q, priv_d;
  logic [7:0]  scfsi_q, scfsi_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        gr_q, gr_d;
  logic        ch_q, ch_d;
  logic [11:0] p23_q, p23_d;
  logic [8:0]  bv_q, bv_d;
  logic [7:0]  gg_q, gg_d;
  logic [3:0]  sc_q, sc_d;
  logic        ws_q, ws_d;
  logic [1:0]  bt_q, bt_d;
  logic        mb_q, mb_d;
  logic [14:0] ts_q, ts_d;
  logic [8:0]  sg_q, sg_d;
  logic [3:0]  r0_q, r0_d;
  logic [2:0]  r1_q, r1_d;
  logic        pre_q, pre_d;
  logic        ss_q, ss_d;
  logic        c1_q, c1_d;
  logic        rec_valid_q, rec_valid_d;
  logic        done_q, done_d;

  logic [5:0]  len;
  logic        accept;
  logic        last_byte;
  logic        last_rec;
  logic [7:0]  base;
  logic [58:0] rb;

  // Byte acceptance, record selection and drop detection
  always_comb begin
    len       = mono_q ? 6'(MONO_BYTES) : 6'(STEREO_BYTES);
    accept    = (state_q == COLLECT) && side_info_ov
                && !valid_header && (cnt_q < len);
    last_byte = accept && (cnt_q == len - 6'd1);
    last_rec  = mono_q ? (idx_q == 2'd1) : (idx_q == 2'd3);
    base      = mono_q ? 8'd18 + 8'd59 * {6'd0, idx_q}
                       : 8'd20 + 8'd59 * {6'd0, idx_q};
    rb        = 59'((cap_q << base) >> 197);
    overrun   = !rst && side_info_ov && !accept;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (valid_header) state_d = COLLECT;
      COLLECT:  if (last_byte) state_d = EMIT_HDR;
      EMIT_HDR: state_d = EMIT_REC;
      EMIT_REC: if (last_rec) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Capture datapath and decoded output values
  always_comb begin
    mono_d      = mono_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    idx_d       = idx_q;
    hdr_valid_d = 1'b0;
    rec_valid_d = 1'b0;
    done_d      = 1'b0;
    mdb_d       = mdb_q;
    priv_d      = priv_q;
    scfsi_d     = scfsi_q;
    gr_d        = gr_q;
    ch_d        = ch_q;
    p23_d       = p23_q;
    bv_d        = bv_q;
    gg_d        = gg_q;
    sc_d        = sc_q;
    ws_d        = ws_q;
    bt_d        = bt_q;
    mb_d        = mb_q;
    ts_d        = ts_q;
    sg_d        = sg_q;
    r0_d        = r0_q;
    r1_d        = r1_q;
    pre_d       = pre_q;
    ss_d        = ss_q;
    c1_d        = c1_q;
    if ((state_q == IDLE || state_q == COLLECT) && valid_header) begin
      mono_d = (mode == 2'b11);
      cnt_d  = 6'd0;
      cap_d  = '0;
    end else if (accept) begin
      cap_d = cap_q | ({axiid, 248'd0} >> {cnt_q, 3'b000});
      cnt_d = cnt_q + 6'd1;
    end
    case (state_q)
      EMIT_HDR: begin
        hdr_valid_d = 1'b1;
        idx_d       = 2'd0;
        mdb_d       = cap_q[255:247];
        if (mono_q) begin
          priv_d  = cap_q[246:242];
          scfsi_d = {cap_q[241:238], 4'd0};
        end else begin
          priv_d  = {2'd0, cap_q[246:244]};
          scfsi_d = cap_q[243:236];
        end
      end
      EMIT_REC: begin
        rec_valid_d = 1'b1;
        idx_d       = idx_q + 2'd1;
        gr_d        = mono_q ? idx_q[0] : idx_q[1];
        ch_d        = mono_q ? 1'b0 : idx_q[0];
        p23_d       = rb[58:47];
        bv_d        = rb[46:38];
        gg_d        = rb[37:30];
        sc_d        = rb[29:26];
        ws_d        = rb[25];
        if (rb[25]) begin
          bt_d = rb[24:23];
          mb_d = rb[22];
          ts_d = {rb[21:12], 5'd0};
          sg_d = rb[11:3];
          r0_d = (rb[24:23] == 2'd2 && !rb[22]) ? 4'd8 : 4'd7;
          r1_d = 3'd0;
        end else begin
          bt_d = 2'd0;
          mb_d = 1'b0;
          ts_d = rb[24:10];
          sg_d = 9'd0;
          r0_d = rb[9:6];
          r1_d = rb[5:3];
        end
        pre_d = rb[2];
        ss_d  = rb[1];
        c1_d  = rb[0];
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mono_q      <= 1'b0;
      cnt_q       <= '0;
      cap_q       <= '0;
      idx_q       <= '0;
      mdb_q       <= '0;
      priv_q      <= '0;
      scfsi_q     <= '0;
      hdr_valid_q <= 1'b0;
      gr_q        <= 1'b0;
      ch_q        <= 1'b0;
      p23_q       <= '0;
      bv_q        <= '0;
      gg_q        <= '0;
      sc_q        <= '0;
      ws_q        <= 1'b0;
      bt_q        <= '0;
      mb_q        <= 1'b0;
      ts_q        <= '0;
      sg_q        <= '0;
      r0_q        <= '0;
      r1_q        <= '0;
      pre_q       <= 1'b0;
      ss_q        <= 1'b0;
      c1_q        <= 1'b0;
      rec_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mono_q      <= mono_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      idx_q       <= idx_d;
      mdb_q       <= mdb_d;
      priv_q      <= priv_d;
      scfsi_q     <= scfsi_d;
      hdr_valid_q <= hdr_valid_d;
      gr_q        <= gr_d;
      ch_q        <= ch_d;
      p23_q       <= p23_d;
      bv_q        <= bv_d;
      gg_q        <= gg_d;
      sc_q        <= sc_d;
      ws_q        <= ws_d;
      bt_q        <= bt_d;
      mb_q        <= mb_d;
      ts_q        <= ts_d;
      sg_q        <= sg_d;
      r0_q        <= r0_d;
      r1_q        <= r1_d;
      pre_q       <= pre_d;
      ss_q        <= ss_d;
      c1_q        <= c1_d;
      rec_valid_q <= rec_valid_d;
      done_q      <= done_d;
    end
  end

  assign main_data_begin    = mdb_q;
  assign private_bits       = priv_q;
  assign scfsi              = scfsi_q;
  assign hdr_valid          = hdr_valid_q;
  assign gr                 = gr_q;
  assign ch                 = ch_q;
  assign part2_3_length     = p23_q;
  assign big_values         = bv_q;
  assign global_gain        = gg_q;
  assign scalefac_compress  = sc_q;
  assign window_switching   = ws_q;
  assign block_type         = bt_q;
  assign mixed_block        = mb_q;
  assign table_select       = ts_q;
  assign subblock_gain      = sg_q;
  assign region0_count      = r0_q;
  assign region1_count      = r1_q;
  assign preselect          = pre_q;
  assign scalefac_scale     = ss_q;
  assign count1table_select = c1_q;
  assign rec_valid          = rec_valid_q;
  assign done               = done_q;

endmodule

// File: tb/tb_side_info_parser.sv
// tb_side_info_parser: directed frames with a queue scoreboard; a monitor
// pops expected header/record/done entries whenever the DUT strobes.
module tb_side_info_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_header = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  axiid = 8'h00;
  logic        side_info_ov = 1'b0;
  logic [8:0]  main_data_begin;
  logic [4:0]  private_bits;
  logic [7:0]  scfsi;
  logic        hdr_valid;
  logic        gr, ch;
  logic [11:0] part2_3_length;
  logic [8:0]  big_values;
  logic [7:0]  global_gain;
  logic [3:0]  scalefac_compress;
  logic        window_switching;
  logic [1:0]  block_type;
  logic        mixed_block;
  logic [14:0] table_select;
  logic [8:0]  subblock_gain;
  logic [3:0]  region0_count;
  logic [2:0]  region1_count;
  logic        preselect, scalefac_scale, count1table_select;
  logic        rec_valid, done, overrun;

  side_info_parser dut (
    .clk(clk), .rst(rst), .valid_header(valid_header), .mode(mode),
    .axiid(axiid), .side_info_ov(side_info_ov),
    .main_data_begin(main_data_begin), .private_bits(private_bits),
    .scfsi(scfsi), .hdr_valid(hdr_valid), .gr(gr), .ch(ch),
    .part2_3_length(part2_3_length), .big_values(big_values),
    .global_gain(global_gain), .scalefac_compress(scalefac_compress),
    .window_switching(window_switching), .block_type(block_type),
    .mixed_block(mixed_block), .table_select(table_select),
    .subblock_gain(subblock_gain), .region0_count(region0_count),
    .region1_count(region1_count), .preselect(preselect),
    .scalefac_scale(scalefac_scale),
    .count1table_select(count1table_select),
    .rec_valid(rec_valid), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        gr;
    logic        ch;
    logic [11:0] p23;
    logic [8:0]  bv;
    logic [7:0]  gg;
    logic [3:0]  sc;
    logic        ws;
    logic [1:0]  bt;
    logic        mb;
    logic [14:0] ts;
    logic [8:0]  sg;
    logic [3:0]  r0;
    logic [2:0]  r1;
    logic        pre;
    logic        ss;
    logic        c1;
  } rec_t;

  typedef struct packed {
    logic [8:0] mdb;
    logic [4:0] priv;
    logic [7:0] scfsi;
  } hdr_t;

  hdr_t hq[$];
  rec_t rq[$];
  int   dq = 0;
  int   total = 0, bad = 0;
  int   cyc = 0, last_byte_cyc = 0;
  int   exp_ov = 0, seen_ov = 0;
  bit   no_push = 1'b0;
  bit   prev_rec = 1'b0;
  logic [255:0] img;
  int   pos;
  rec_t act_rec, er;
  hdr_t act_hdr, eh;
  logic [98:0] all_out;

  assign act_rec = {gr, ch, part2_3_length, big_values, global_gain,
                    scalefac_compress, window_switching, block_type,
                    mixed_block, table_select, subblock_gain,
                    region0_count, region1_count, preselect,
                    scalefac_scale, count1table_select};
  assign act_hdr = {main_data_begin, private_bits, scfsi};
  assign all_out = {act_hdr, hdr_valid, act_rec, rec_valid, done, overrun};

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic flag(string nm);
    total++;
    bad++;
    $display("FAIL %s actual=strobe required=none", nm);
  endtask

  task automatic start_frame();
    img = '0;
    pos = 0;
  endtask

  task automatic put(int w, logic [31:0] v);
    for (int i = 0; i < w; i++) img[255 - pos - i] = v[w - 1 - i];
    pos += w;
  endtask

  task automatic shdr(logic [8:0] mdb, logic [4:0] pv, logic [7:0] sf,
                      bit mono);
    hdr_t h;
    put(9, 32'(mdb));
    if (mono) begin
      put(5, 32'(pv));
      put(4, 32'(sf[7:4]));
    end else begin
      put(3, 32'(pv[2:0]));
      put(8, 32'(sf));
    end
    h = '{mdb, pv, sf};
    hq.push_back(h);
  endtask

  task automatic rec_ws(bit g, bit c, logic [11:0] p23, logic [8:0] bv,
                        logic [7:0] gg, logic [3:0] sc, logic [1:0] bt,
                        bit mb, logic [4:0] t0, logic [4:0] t1,
                        logic [8:0] sg, bit pre, bit ss, bit c1,
                        logic [3:0] r0);
    rec_t r;
    put(12, 32'(p23)); put(9, 32'(bv)); put(8, 32'(gg));
    put(4, 32'(sc)); put(1, 1); put(2, 32'(bt)); put(1, 32'(mb));
    put(5, 32'(t0)); put(5, 32'(t1)); put(9, 32'(sg));
    put(1, 32'(pre)); put(1, 32'(ss)); put(1, 32'(c1));
    r = '{g, c, p23, bv, gg, sc, 1'b1, bt, mb, {t0, t1, 5'd0}, sg,
          r0, 3'd0, pre, ss, c1};
    if (!no_push) rq.push_back(r);
  endtask

  task automatic rec_nm(bit g, bit c, logic [11:0] p23, logic [8:0] bv,
                        logic [7:0] gg, logic [3:0] sc, logic [14:0] ts,
                        logic [3:0] r0, logic [2:0] r1,
                        bit pre, bit ss, bit c1);
    rec_t r;
    put(12, 32'(p23)); put(9, 32'(bv)); put(8, 32'(gg));
    put(4, 32'(sc)); put(1, 0); put(15, 32'(ts));
    put(4, 32'(r0)); put(3, 32'(r1));
    put(1, 32'(pre)); put(1, 32'(ss)); put(1, 32'(c1));
    r = '{g, c, p23, bv, gg, sc, 1'b0, 2'd0, 1'b0, ts, 9'd0,
          r0, r1, pre, ss, c1};
    if (!no_push) rq.push_back(r);
  endtask

  task automatic hdr(logic [1:0] m, bit with_byte);
    valid_header = 1'b1;
    mode = m;
    if (with_byte) begin
      side_info_ov = 1'b1;
      axiid = 8'hAA;
      exp_ov++;
    end
    @(posedge clk); #1;
    valid_header = 1'b0;
    side_info_ov = 1'b0;
  endtask

  task automatic send(int n, int gap);
    for (int i = 0; i < n; i++) begin
      side_info_ov = 1'b1;
      axiid = img[255 - 8 * i -: 8];
      last_byte_cyc = cyc;
      @(posedge clk); #1;
      side_info_ov = 1'b0;
      repeat (gap - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (hdr_valid) begin
      if (hq.size() == 0) flag("unexpected_hdr");
      else begin
        eh = hq.pop_front();
        chk("hdr_fields", 128'(act_hdr), 128'(eh));
        chk("hdr_latency", 128'(cyc - last_byte_cyc), 128'(2));
      end
    end
    if (rec_valid) begin
      if (rq.size() == 0) flag("unexpected_rec");
      else begin
        er = rq.pop_front();
        chk("rec_fields", 128'(act_rec), 128'(er));
      end
    end
    if (done) begin
      if (dq == 0) flag("unexpected_done");
      else begin
        dq--;
        chk("done_after_last_rec", 128'(prev_rec), 128'(1));
      end
    end
    if (overrun) seen_ov++;
    prev_rec = rec_valid;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 128'(all_out), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // mono frame, spaced bytes
    start_frame();
    img[255:240] = 16'hFF80;
    eh = '{9'h1FF, 5'd0, 8'd0};
    hq.push_back(eh);
    er = '0;
    rq.push_back(er);
    er.gr = 1'b1;
    rq.push_back(er);
    dq++;
    hdr(2'b11, 1'b0);
    send(17, 6);
    repeat (10) @(posedge clk);
    #1;

    // stereo frame, back-to-back, plus a dropped byte during records
    start_frame();
    shdr(9'h155, 5'd5, 8'hA5, 1'b0);
    rec_ws(0, 0, 12'hABC, 9'h120, 8'h5A, 4'h9, 2'd2, 0, 5'd17, 5'd4,
           {3'd3, 3'd5, 3'd7}, 1, 0, 1, 4'd8);
    rec_nm(0, 1, 12'h001, 9'h1FF, 8'hFF, 4'h0, {5'd3, 5'd7, 5'd31},
           4'd9, 3'd5, 0, 1, 0);
    rec_ws(1, 0, 12'h800, 9'h001, 8'h01, 4'hF, 2'd1, 1, 5'd31, 5'd0,
           {3'd7, 3'd0, 3'd7}, 0, 1, 1, 4'd7);
    rec_ws(1, 1, 12'hFFF, 9'h0AA, 8'h80, 4'h3, 2'd2, 1, 5'd1, 5'd2,
           {3'd1, 3'd2, 3'd3}, 1, 1, 1, 4'd7);
    dq++;
    hdr(2'b00, 1'b0);
    send(32, 1);
    @(posedge clk); #1;
    side_info_ov = 1'b1;
    axiid = 8'h77;
    exp_ov++;
    @(posedge clk); #1;
    side_info_ov = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // abandoned mono frame, restarted as stereo with gapped bytes
    img = {32{8'hEE}};
    hdr(2'b11, 1'b0);
    send(10, 2);
    hdr(2'b00, 1'b0);
    start_frame();
    shdr(9'h0A3, 5'd3, 8'h3C, 1'b0);
    rec_nm(0, 0, 12'h123, 9'h045, 8'h67, 4'h8, 15'h1234, 4'd15, 3'd7,
           1, 1, 1);
    rec_nm(0, 1, 12'h000, 9'h000, 8'h00, 4'h0, 15'h7FFF, 4'd0, 3'd0,
           0, 0, 0);
    rec_nm(1, 0, 12'hFFF, 9'h1FF, 8'hFF, 4'hF, 15'h0001, 4'd1, 3'd1,
           1, 0, 1);
    rec_nm(1, 1, 12'h5A5, 9'h0F0, 8'h3C, 4'h6, 15'h4000, 4'd6, 3'd2,
           0, 1, 1);
    dq++;
    send(32, 3);
    repeat (10) @(posedge clk);
    #1;

    // header with a simultaneous byte, then reset after the second record
    start_frame();
    shdr(9'h1C7, 5'd6, 8'h81, 1'b0);
    rec_nm(0, 0, 12'h321, 9'h111, 8'h22, 4'h3, 15'h2AAA, 4'd4, 3'd4,
           1, 0, 0);
    rec_ws(0, 1, 12'h654, 9'h0CC, 8'h44, 4'h5, 2'd3, 0, 5'd9, 5'd10,
           {3'd4, 3'd4, 3'd4}, 0, 0, 1, 4'd7);
    no_push = 1'b1;
    rec_nm(1, 0, 12'hEEE, 9'h1EE, 8'hEE, 4'hE, 15'h5555, 4'd2, 3'd3,
           1, 1, 0);
    rec_nm(1, 1, 12'hDDD, 9'h1DD, 8'hDD, 4'hD, 15'h6666, 4'd5, 3'd6,
           0, 1, 0);
    no_push = 1'b0;
    hdr(2'b00, 1'b1);
    send(32, 1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("reset_mid_records", 128'(all_out), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    chk("hdr_queue_empty", 128'(hq.size()), 128'(0));
    chk("rec_queue_empty", 128'(rq.size()), 128'(0));
    chk("done_pending", 128'(dq), 128'(0));
    chk("overrun_count", 128'(seen_ov), 128'(exp_ov));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
